ri_golomb_param: RTL and testbench



---
 rtl/ri_golomb_param_pkg.sv | 18 +
 rtl/ri_map_errval.sv | 54 +++++
 rtl/ri_golomb_param.sv | 143 ++++++++++++++
 tb/tb_ri_golomb_param.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ri_golomb_param_pkg.sv
// Shared constants for the run-interruption Golomb parameter stage: default
// widths, the k saturation bound and the FSM state encodings.
package ri_golomb_param_pkg;

  // Default widths and bounds.
  localparam int unsigned TempLength   = 22;
  localparam int unsigned NLength      = 7;
  localparam int unsigned KLength      = 5;
  localparam int unsigned KMax         = 16;
  localparam int unsigned ErrvalLength = 9;
  localparam int unsigned EmerrLength  = 10;

  // FSM state encodings.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

endpackage

// File: rtl/ri_map_errval.sv
// Map bit and mapped error for a run-interruption sample. Purely
// combinational; the parent registers the results when the k search ends.
module ri_map_errval #(
  parameter int unsigned errval_length = 9,
  parameter int unsigned k_length      = 5,
  parameter int unsigned N_length      = 7,
  parameter int unsigned emerr_length  = 10
) (
  input  logic [errval_length-1:0] Errval,
  input  logic [k_length-1:0]      k,
  input  logic [N_length-1:0]      N,
  input  logic [N_length-1:0]      Nn,
  input  logic                     RIType,
  output logic                     map,
  output logic [emerr_length-1:0]  EMErrval
);

  logic                     errval_neg;
  logic                     errval_pos;
  logic                     k_zero;
  logic [N_length:0]        nn_x2;
  logic [N_length:0]        n_ext;
  logic                     nn_x2_lt_n;
  logic [errval_length-1:0] abs_err;
  logic [emerr_length:0]    two_abs;
  logic [emerr_length:0]    diff;

  // Sign tests and the 2*Nn < N comparison, one bit wider than N so 2*Nn never overflows.
  always_comb begin
    errval_neg = Errval[errval_length-1];
    errval_pos = !errval_neg && (Errval != '0);
    k_zero     = (k == '0);
    nn_x2      = {Nn, 1'b0};
    n_ext      = {1'b0, N};
    nn_x2_lt_n = (nn_x2 < n_ext);
  end

  // Map bit selection.
  always_comb begin
    map = (k_zero && errval_pos && nn_x2_lt_n) ||
          (errval_neg && !nn_x2_lt_n) ||
          (errval_neg && !k_zero);
  end

  // EMErrval = 2*|Errval| - RIType - map with one guard bit; a negative result clamps to 0.
  always_comb begin
    // Unsigned magnitude: the most negative Errval maps onto its exact magnitude.
    abs_err  = errval_neg ? -Errval : Errval;
    two_abs  = (emerr_length + 1)'({abs_err, 1'b0});
    diff     = two_abs - (emerr_length + 1)'(RIType) - (emerr_length + 1)'(map);
    EMErrval = diff[emerr_length] ? '0 : diff[emerr_length-1:0];
  end

endmodule

// File: rtl/ri_golomb_param.sv
// Run-interruption Golomb parameter stage. Latches temp/N/Nn/RIType/Errval,
// finds the smallest k with (N << k) >= temp (saturating at K_MAX) one compare
// per cycle, then presents k, map and EMErrval over a valid/ready handshake.
module ri_golomb_param
  import ri_golomb_param_pkg::*;
#(
  parameter int unsigned temp_length   = TempLength,
  parameter int unsigned N_length      = NLength,
  parameter int unsigned k_length      = KLength,
  parameter int unsigned K_MAX         = KMax,
  parameter int unsigned errval_length = ErrvalLength,
  parameter int unsigned emerr_length  = EmerrLength
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [temp_length-1:0]   temp,
  input  logic [N_length-1:0]      N_Select,
  input  logic [N_length-1:0]      Nn_Select,
  input  logic                     RIType,
  input  logic [errval_length-1:0] Errval,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [k_length-1:0]      k,
  output logic                     map,
  output logic [emerr_length-1:0]  EMErrval
);

  localparam int unsigned ShiftLength = N_length + K_MAX;
  localparam int unsigned CmpLength   = ShiftLength + temp_length;
  localparam logic [k_length-1:0] KMaxK = k_length'(K_MAX);

  logic [1:0]               state_q, state_d;
  logic [temp_length-1:0]   temp_q;
  logic [N_length-1:0]      n_q;
  logic [N_length-1:0]      nn_q;
  logic                     ritype_q;
  logic [errval_length-1:0] errval_q;
  logic [ShiftLength-1:0]   shift_q;
  logic [k_length-1:0]      k_cnt_q;
  logic [k_length-1:0]      k_q;
  logic                     map_q;
  logic [emerr_length-1:0]  emerr_q;

  logic                     accept;
  logic                     found;
  logic                     map_c;
  logic [emerr_length-1:0]  emerr_c;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign k         = k_q;
  assign map       = map_q;
  assign EMErrval  = emerr_q;

  // Search ends when the shifted N covers temp or k has reached its bound.
  always_comb begin
    found = (CmpLength'(shift_q) >= CmpLength'(temp_q)) || (k_cnt_q == KMaxK);
  end

  // Map/EMErrval for the candidate k; only sampled on the cycle the search ends.
  ri_map_errval #(
    .errval_length(errval_length),
    .k_length     (k_length),
    .N_length     (N_length),
    .emerr_length (emerr_length)
  ) u_map_errval (
    .Errval  (errval_q),
    .k       (k_cnt_q),
    .N       (n_q),
    .Nn      (nn_q),
    .RIType  (ritype_q),
    .map     (map_c),
    .EMErrval(emerr_c)
  );

  // FSM next state: IDLE -> SEARCH on accept, SEARCH -> DONE on found, DONE -> IDLE on out_ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = SEARCH;
      SEARCH:  if (found)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture; later input changes cannot disturb the running search.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      temp_q   <= '0;
      n_q      <= '0;
      nn_q     <= '0;
      ritype_q <= 1'b0;
      errval_q <= '0;
    end else if (accept) begin
      temp_q   <= temp;
      n_q      <= N_Select;
      nn_q     <= Nn_Select;
      ritype_q <= RIType;
      errval_q <= Errval;
    end
  end

  // Shift register and k counter: seeded on accept, stepped while the search continues.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      k_cnt_q <= '0;
    end else if (accept) begin
      shift_q <= ShiftLength'(N_Select);
      k_cnt_q <= '0;
    end else if ((state_q == SEARCH) && !found) begin
      shift_q <= shift_q << 1;
      k_cnt_q <= k_cnt_q + k_length'(1);
    end
  end

  // Result registers: loaded once when the search ends, held through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q     <= '0;
      map_q   <= 1'b0;
      emerr_q <= '0;
    end else if ((state_q == SEARCH) && found) begin
      k_q     <= k_cnt_q;
      map_q   <= map_c;
      emerr_q <= emerr_c;
    end
  end

endmodule

// File: tb/tb_ri_golomb_param.sv
// Bench for ri_golomb_param: directed cases plus random operands against an
// arithmetic reference model of k, map and EMErrval.
module tb_ri_golomb_param;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] temp;
  logic [6:0]  N_Select;
  logic [6:0]  Nn_Select;
  logic        RIType;
  logic [8:0]  Errval;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  k;
  logic        map;
  logic [9:0]  EMErrval;

  int n_checks;
  int n_fail;

  typedef struct {
    int temp;
    int n;
    int nn;
    int ritype;
    int errval;
  } op_t;

  ri_golomb_param dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .temp     (temp),
    .N_Select (N_Select),
    .Nn_Select(Nn_Select),
    .RIType   (RIType),
    .Errval   (Errval),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .k        (k),
    .map      (map),
    .EMErrval (EMErrval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: smallest k with N*2^k >= temp, capped at 16; map and EMErrval from their rules.
  function automatic void model(input op_t o, output int ek, output int em, output int eem);
    longint sh;
    int     e;
    int     a;
    sh = longint'(o.n);
    ek = 0;
    while (sh < longint'(o.temp) && ek < 16) begin
      sh = sh * 2;
      ek++;
    end
    e  = o.errval;
    em = ((ek == 0 && e > 0 && 2 * o.nn < o.n) ||
          (e < 0 && 2 * o.nn >= o.n) ||
          (e < 0 && ek != 0)) ? 1 : 0;
    a   = (e < 0) ? -e : e;
    eem = 2 * a - o.ritype - em;
    if (eem < 0) eem = 0;
  endfunction

  function automatic op_t mk(input int t, input int n, input int nn, input int rt, input int e);
    op_t o;
    o.temp = t; o.n = n; o.nn = nn; o.ritype = rt; o.errval = e;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.temp   = int'($urandom_range(0, (1 << $urandom_range(0, 21)) - 1));
    o.n      = int'($urandom_range(0, 127));
    o.nn     = int'($urandom_range(0, 127));
    o.ritype = int'($urandom_range(0, 1));
    o.errval = int'($urandom_range(0, 511)) - 256;
    return o;
  endfunction

  task automatic drive(input op_t o);
    temp      = 22'(o.temp);
    N_Select  = 7'(o.n);
    Nn_Select = 7'(o.nn);
    RIType    = o.ritype[0];
    Errval    = 9'(o.errval);
  endtask

  // Called at a negedge with in_valid already high; returns at the negedge after the accept edge.
  task automatic accept();
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    drive(rand_op());  // scramble ports: result must come from latched operands
  endtask

  // Counts edges from the accept edge (inclusive) to the first out_valid, then checks results.
  task automatic wait_result(input op_t o, input string tag);
    int ek, em, eem, edges;
    model(o, ek, em, eem);
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(ek + 2));
    check({tag, "_k"}, 32'(k), 32'(ek));
    check({tag, "_map"}, 32'(map), 32'(em));
    check({tag, "_emerr"}, 32'(EMErrval), 32'(eem));
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("released_out_valid", 32'(out_valid), 32'd0);
    check("released_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run(input op_t o, input string tag);
    drive(o);
    in_valid = 1'b1;
    accept();
    wait_result(o, tag);
    release_out();
  endtask

  initial begin
    op_t a, b;
    int  ek, em, eem;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_k", 32'(k), 32'd0);
    check("reset_map", 32'(map), 32'd0);
    check("reset_emerr", 32'(EMErrval), 32'd0);

    run(mk(0, 1, 0, 0, 1), "temp_zero");
    run(mk(20, 3, 1, 0, -2), "k3");
    run(mk(3, 4, 1, 1, 3), "nn1");
    run(mk(3, 4, 2, 1, 3), "nn2");
    run(mk(1 << 20, 1, 0, 0, 5), "sat");
    run(mk(100, 0, 0, 0, -7), "n_zero_sat");
    run(mk(0, 5, 2, 1, 0), "clamp");
    run(mk(7, 9, 3, 0, -256), "errval_min");

    // Backpressure: outputs hold 10 cycles while a new request waits, unaccepted.
    a = mk(50, 2, 1, 1, 9);
    b = mk(9, 2, 0, 0, -4);
    model(a, ek, em, eem);
    drive(a);
    in_valid = 1'b1;
    accept();
    wait_result(a, "bp");
    drive(b);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_k", 32'(k), 32'(ek));
      check("bp_map", 32'(map), 32'(em));
      check("bp_emerr", 32'(EMErrval), 32'(eem));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_handshake_in_ready", 32'(in_ready), 32'd1);
    check("bp_handshake_out_valid", 32'(out_valid), 32'd0);
    accept();
    wait_result(b, "bp_next");
    release_out();

    // Reset during the 3rd SEARCH cycle abandons the operation.
    run(mk(1 << 20, 1, 0, 0, 5), "pre_reset");
    drive(mk(20, 3, 1, 0, -2));
    in_valid = 1'b1;
    accept();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_k", 32'(k), 32'd0);
    check("midrst_map", 32'(map), 32'd0);
    check("midrst_emerr", 32'(EMErrval), 32'd0);
    run(mk(20, 3, 1, 0, -2), "post_reset");

    for (int i = 0; i < 60; i++) begin
      run(rand_op(), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
